uart_tx_buffered: RTL and testbench

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_sync_fifo.sv | 61 ++++++
 rtl/uart_tx_buffered.sv | 181 ++++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM state encoding,
// line-configuration constants and the parity helper.
package uart_pkg;

  // Transmitter frame states, in the order a frame walks through them.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // parity_type encodings
  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // stop_bits encodings
  localparam logic STOP_ONE = 1'b0;
  localparam logic STOP_TWO = 1'b1;

  // Widest frame payload the transmitter supports.
  localparam int MAX_DATA_WIDTH = 9;

  // Parity bit for a data word; callers zero-extend narrower words, which
  // leaves the XOR reduction unchanged.
  function automatic logic calc_parity(input logic [MAX_DATA_WIDTH-1:0] data,
                                       input logic                      ptype);
    return (^data) ^ (ptype == PARITY_ODD);
  endfunction

endpackage : uart_pkg

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO. Pushes while full and pops while empty are
// ignored; full/empty are decoded from the registered occupancy count.
module uart_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr_q];

  // Pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array write port.
  // NOTE: the data array has no reset; the pointers and count define which
  // entries are valid, so clearing the storage would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule : uart_sync_fifo

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: words queue in a FIFO and are serialised LSB
// first with optional parity and one or two stop bits. Line settings are
// captured when a word is popped and stay fixed for that frame.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [DATA_WIDTH-1:0]       TX_IN_P,
  input  logic                        TX_IN_V,
  output logic                        TX_IN_READY,
  input  logic [DIV_WIDTH-1:0]        Baud_Div,
  input  logic                        parity_enable,
  input  logic                        parity_type,
  input  logic                        stop_bits,
  output logic                        TX_OUT_S,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        fifo_full,
  output logic                        fifo_empty,
  output logic                        overflow
);

  localparam int BIT_CNT_W = $clog2(DATA_WIDTH);

  tx_state_e             state_q, state_d;
  logic [DIV_WIDTH-1:0]  baud_cnt_q, baud_cnt_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  stop2_q, stop2_d;
  logic                  tx_q, tx_d;
  logic                  overflow_q;
  logic                  bit_last;
  logic                  load_frame;
  logic                  fifo_pop;
  logic [DATA_WIDTH-1:0] fifo_rdata;

  uart_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST),
    .push  (TX_IN_V),
    .wdata (TX_IN_P),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign TX_IN_READY = !fifo_full;
  assign TX_OUT_S    = tx_q;
  assign busy        = (state_q != ST_IDLE);
  assign overflow    = overflow_q;

  // Last cycle of the current bit; a divisor of 0 behaves like 1.
  assign bit_last = (div_q <= DIV_WIDTH'(1)) ? (baud_cnt_q == '0)
                                             : (baud_cnt_q == div_q - DIV_WIDTH'(1));

  // Next-state, counter, shifter and serial-line decode.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    baud_cnt_d = bit_last ? '0 : baud_cnt_q + DIV_WIDTH'(1);
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    div_d      = div_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    load_frame = 1'b0;
    tx_d       = 1'b1;

    case (state_q)
      ST_IDLE: begin
        baud_cnt_d = '0;
        if (!fifo_empty) load_frame = 1'b1;
      end
      ST_START: begin
        if (bit_last) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_last) begin
          if (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH - 1)) begin
            state_d   = par_en_q ? ST_PARITY : ST_STOP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            shift_d   = shift_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_last) begin
          state_d   = ST_STOP;
          bit_cnt_d = '0;
        end
      end
      ST_STOP: begin
        if (bit_last) begin
          if (bit_cnt_q == BIT_CNT_W'(stop2_q)) begin
            if (!fifo_empty) load_frame = 1'b1;
            else             state_d    = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pop the next word and capture the line settings for its frame.
    if (load_frame) begin
      state_d    = ST_START;
      baud_cnt_d = '0;
      bit_cnt_d  = '0;
      shift_d    = fifo_rdata;
      div_d      = Baud_Div;
      par_en_d   = parity_enable;
      par_bit_d  = calc_parity(MAX_DATA_WIDTH'(fifo_rdata), parity_type);
      stop2_d    = (stop_bits == STOP_TWO);
    end

    // Line level for the state being entered, so TX_OUT_S is a clean register.
    case (state_d)
      ST_IDLE:   tx_d = 1'b1;
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_bit_d;
      ST_STOP:   tx_d = 1'b1;
      default:   tx_d = 1'b1;
    endcase
  end

  assign fifo_pop = load_frame;

  // Frame state, counters, shifter, latched settings and line register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      div_q      <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      div_q      <= div_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      tx_q       <= tx_d;
    end
  end

  // One-cycle pulse for a write attempted while the FIFO is full.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) overflow_q <= 1'b0;
    else      overflow_q <= TX_IN_V && fifo_full;
  end

endmodule : uart_tx_buffered

// File: tb/tb_uart_tx_buffered.sv
// Directed testbench for uart_tx_buffered: reset values, single frames with
// and without parity, divisor 0, back-to-back frames, FIFO fill/overflow with
// pointer wrap, and reset in the middle of a frame.
module tb_uart_tx_buffered;

  logic        CLK;
  logic        RST;
  logic [7:0]  TX_IN_P;
  logic        TX_IN_V;
  logic        TX_IN_READY;
  logic [15:0] Baud_Div;
  logic        parity_enable;
  logic        parity_type;
  logic        stop_bits;
  logic        TX_OUT_S;
  logic        busy;
  logic [4:0]  fifo_count;
  logic        fifo_full;
  logic        fifo_empty;
  logic        overflow;

  int tests_run;
  int tests_failed;

  uart_tx_buffered #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (16),
    .DIV_WIDTH  (16)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .TX_IN_P       (TX_IN_P),
    .TX_IN_V       (TX_IN_V),
    .TX_IN_READY   (TX_IN_READY),
    .Baud_Div      (Baud_Div),
    .parity_enable (parity_enable),
    .parity_type   (parity_type),
    .stop_bits     (stop_bits),
    .TX_OUT_S      (TX_OUT_S),
    .busy          (busy),
    .fifo_count    (fifo_count),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .overflow      (overflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Hard time limit so the run always ends.
  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

  // Present one word for a single clock; returns at the negedge after the
  // accepting edge.
  task automatic write_word(input logic [7:0] data);
    @(negedge CLK);
    TX_IN_P = data;
    TX_IN_V = 1'b1;
    @(negedge CLK);
    TX_IN_V = 1'b0;
  endtask

  // Write one word into an idle block and compare the line cycle by cycle
  // against a hand-written frame (bit 0 sent first).
  task automatic send_and_check_frame(input string       name,
                                      input logic [7:0]  data,
                                      input logic [15:0] frame,
                                      input int          nbits,
                                      input int          div);
    int   eff;
    int   busy_cycles;
    logic exp;
    eff = (div == 0) ? 1 : div;
    write_word(data);
    tests_run++;
    if (TX_OUT_S !== 1'b1 || busy !== 1'b0 || fifo_count !== 5'd1) begin
      tests_failed++;
      $display("FAIL %s pre-start: line=%b busy=%b count=%0d, expected line=1 busy=0 count=1",
               name, TX_OUT_S, busy, fifo_count);
    end
    busy_cycles = 0;
    for (int j = 0; j < nbits * eff + 4; j++) begin
      @(negedge CLK);
      exp = (j < nbits * eff) ? frame[j / eff] : 1'b1;
      tests_run++;
      if (TX_OUT_S !== exp) begin
        tests_failed++;
        $display("FAIL %s line cycle %0d: got %b, expected %b", name, j, TX_OUT_S, exp);
      end
      if (busy === 1'b1) busy_cycles++;
    end
    tests_run++;
    if (busy_cycles != nbits * eff) begin
      tests_failed++;
      $display("FAIL %s busy length: got %0d cycles, expected %0d", name, busy_cycles, nbits * eff);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    tests_run++;
    if (TX_OUT_S !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0 || fifo_count !== 5'd0 ||
        fifo_empty !== 1'b1 || fifo_full !== 1'b0 || TX_IN_READY !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset values: line=%b busy=%b ovf=%b count=%0d empty=%b full=%b ready=%b, expected 1 0 0 0 1 0 1",
               TX_OUT_S, busy, overflow, fifo_count, fifo_empty, fifo_full, TX_IN_READY);
    end
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    tests_run++;
    if (TX_OUT_S !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL post-reset idle: line=%b busy=%b, expected line=1 busy=0", TX_OUT_S, busy);
    end
  endtask

  task automatic test_basic_frame();
    Baud_Div = 16'd4; parity_enable = 1'b0; parity_type = 1'b0; stop_bits = 1'b0;
    // 0xA5 LSB first: 1,0,1,0,0,1,0,1 framed by start 0 and stop 1
    send_and_check_frame("basic_A5", 8'hA5, {6'd0, 1'b1, 8'hA5, 1'b0}, 10, 4);
  endtask

  task automatic test_parity();
    Baud_Div = 16'd4; parity_enable = 1'b1; stop_bits = 1'b0;
    // 0xA5 has four ones: even parity bit 0, odd parity bit 1
    parity_type = 1'b0;
    send_and_check_frame("parity_even", 8'hA5, {5'd0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, 4);
    parity_type = 1'b1;
    send_and_check_frame("parity_odd", 8'hA5, {5'd0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11, 4);
    stop_bits = 1'b1;
    send_and_check_frame("parity_odd_2stop", 8'hA5, {4'd0, 2'b11, 1'b1, 8'hA5, 1'b0}, 12, 4);
    // 0x07 has three ones: even parity bit 1
    parity_type = 1'b0; stop_bits = 1'b0;
    send_and_check_frame("parity_even_07", 8'h07, {5'd0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 4);
  endtask

  task automatic test_baud_zero();
    Baud_Div = 16'd0; parity_enable = 1'b0; parity_type = 1'b0; stop_bits = 1'b0;
    send_and_check_frame("baud_zero", 8'h3C, {6'd0, 1'b1, 8'h3C, 1'b0}, 10, 0);
  endtask

  task automatic test_back_to_back();
    logic [29:0] frames;
    logic        exp;
    logic [7:0]  smp_line [0:123];
    Baud_Div = 16'd4; parity_enable = 1'b0; parity_type = 1'b0; stop_bits = 1'b0;
    frames = {1'b1, 8'h03, 1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 8'h01, 1'b0};
    @(negedge CLK); TX_IN_P = 8'h01; TX_IN_V = 1'b1;
    @(negedge CLK); TX_IN_P = 8'h02;
    @(negedge CLK); TX_IN_P = 8'h03; smp_line[0] = {6'd0, busy, TX_OUT_S};
    @(negedge CLK); TX_IN_V = 1'b0;  smp_line[1] = {6'd0, busy, TX_OUT_S};
    tests_run++;
    if (fifo_count !== 5'd2) begin
      tests_failed++;
      $display("FAIL b2b count after writes: got %0d, expected 2", fifo_count);
    end
    for (int j = 2; j < 124; j++) begin
      @(negedge CLK);
      smp_line[j] = {6'd0, busy, TX_OUT_S};
    end
    for (int j = 0; j < 124; j++) begin
      exp = (j < 120) ? frames[j / 4] : 1'b1;
      tests_run++;
      if (smp_line[j][0] !== exp || smp_line[j][1] !== (j < 120)) begin
        tests_failed++;
        $display("FAIL b2b cycle %0d: line=%b busy=%b, expected line=%b busy=%b",
                 j, smp_line[j][0], smp_line[j][1], exp, (j < 120));
      end
    end
    tests_run++;
    if (fifo_count !== 5'd0 || fifo_empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b drained: count=%0d empty=%b, expected 0 1", fifo_count, fifo_empty);
    end
  endtask

  task automatic test_overflow_wrap();
    logic [7:0] w;
    logic       exp;
    int         pos;
    Baud_Div = 16'd100; parity_enable = 1'b0; parity_type = 1'b0; stop_bits = 1'b0;
    // Writes 0..17 land on edges e1..e18.
    for (int i = 0; i < 18; i++) begin
      @(negedge CLK);
      if (i == 2) begin
        tests_run++;
        if (fifo_count !== 5'd1 || busy !== 1'b1 || TX_OUT_S !== 1'b0) begin
          tests_failed++;
          $display("FAIL ovf first pop: count=%0d busy=%b line=%b, expected 1 1 0",
                   fifo_count, busy, TX_OUT_S);
        end
      end
      if (i == 17) begin
        tests_run++;
        if (fifo_count !== 5'd16 || TX_IN_READY !== 1'b0 || fifo_full !== 1'b1 || overflow !== 1'b0) begin
          tests_failed++;
          $display("FAIL ovf after 17th write: count=%0d ready=%b full=%b ovf=%b, expected 16 0 1 0",
                   fifo_count, TX_IN_READY, fifo_full, overflow);
        end
      end
      TX_IN_P = 8'(i);
      TX_IN_V = 1'b1;
    end
    @(negedge CLK); TX_IN_V = 1'b0;
    tests_run++;
    if (overflow !== 1'b1 || fifo_count !== 5'd16) begin
      tests_failed++;
      $display("FAIL ovf pulse: ovf=%b count=%0d, expected 1 16", overflow, fifo_count);
    end
    @(negedge CLK);
    tests_run++;
    if (overflow !== 1'b0 || fifo_count !== 5'd16) begin
      tests_failed++;
      $display("FAIL ovf pulse end: ovf=%b count=%0d, expected 0 16", overflow, fifo_count);
    end
    // Remaining words are popped with divisor 0; word 0 still runs at 100.
    Baud_Div = 16'd0;
    repeat (982) @(negedge CLK);
    tests_run++;
    if (TX_OUT_S !== 1'b1 || busy !== 1'b1 || fifo_count !== 5'd16) begin
      tests_failed++;
      $display("FAIL wrap pre-start: line=%b busy=%b count=%0d, expected 1 1 16",
               TX_OUT_S, busy, fifo_count);
    end
    // Words 1..16, ten one-cycle bits each, contiguous; then idle.
    for (int j = 0; j < 164; j++) begin
      @(negedge CLK);
      w   = 8'(j / 10 + 1);
      pos = j % 10;
      if (j >= 160)      exp = 1'b1;
      else if (pos == 0) exp = 1'b0;
      else if (pos == 9) exp = 1'b1;
      else               exp = w[pos-1];
      tests_run++;
      if (TX_OUT_S !== exp) begin
        tests_failed++;
        $display("FAIL wrap line cycle %0d: got %b, expected %b", j, TX_OUT_S, exp);
      end
    end
    tests_run++;
    if (busy !== 1'b0 || fifo_count !== 5'd0) begin
      tests_failed++;
      $display("FAIL wrap drained: busy=%b count=%0d, expected 0 0", busy, fifo_count);
    end
  endtask

  task automatic test_reset_midframe();
    Baud_Div = 16'd4; parity_enable = 1'b0; parity_type = 1'b0; stop_bits = 1'b0;
    // Six writes on edges k..k+5; the first is popped at k+1, five stay queued.
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      TX_IN_P = 8'(i * 16);
      TX_IN_V = 1'b1;
    end
    @(negedge CLK); TX_IN_V = 1'b0;
    // Data bit 3 occupies edges k+17..k+20; stop after edge k+18.
    repeat (13) @(negedge CLK);
    tests_run++;
    if (TX_OUT_S !== 1'b0 || busy !== 1'b1 || fifo_count !== 5'd5) begin
      tests_failed++;
      $display("FAIL midframe before reset: line=%b busy=%b count=%0d, expected 0 1 5",
               TX_OUT_S, busy, fifo_count);
    end
    RST = 1'b0;
    #1;
    tests_run++;
    if (TX_OUT_S !== 1'b1 || fifo_count !== 5'd0 || busy !== 1'b0 || fifo_empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL midframe async reset: line=%b count=%0d busy=%b empty=%b, expected 1 0 0 1",
               TX_OUT_S, fifo_count, busy, fifo_empty);
    end
    @(negedge CLK);
    RST = 1'b1;
    for (int j = 0; j < 60; j++) begin
      @(negedge CLK);
      tests_run++;
      if (TX_OUT_S !== 1'b1 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL midframe after release cycle %0d: line=%b busy=%b, expected 1 0",
                 j, TX_OUT_S, busy);
      end
    end
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    RST           = 1'b0;
    TX_IN_P       = 8'h00;
    TX_IN_V       = 1'b0;
    Baud_Div      = 16'd4;
    parity_enable = 1'b0;
    parity_type   = 1'b0;
    stop_bits     = 1'b0;

    test_reset();
    test_basic_frame();
    test_parity();
    test_baud_zero();
    test_back_to_back();
    test_overflow_wrap();
    test_reset_midframe();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_uart_tx_buffered
